i2s_dac_transmitter: RTL and testbench

Buffered I2S master transmitter for the DAC end of the audio pipeline. Accepts left/right 24-bit PCM strobes from the output mux, queues stereo pairs in a small FIFO, and generates bclk, lrclk and serial data by dividing the system clock. It reports FIFO level and sticky overflow/underrun status for the CPU status register.

---
 rtl/i2s_dac_transmitter_if.sv | 24 ++
 rtl/i2s_dac_transmitter.sv | 200 ++++++++++++++++++++
 tb/tb_i2s_dac_transmitter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_dac_transmitter_if.sv
// PCM strobe input and I2S serial output bundle for i2s_dac_transmitter.
// master drives PCM and observes the serial side; slave is the transmitter.
interface i2s_dac_transmitter_if;
  localparam int unsigned SAMPLE_W = 24;

  logic                l_data_en;
  logic                r_data_en;
  logic [SAMPLE_W-1:0] l_data;
  logic [SAMPLE_W-1:0] r_data;
  logic                bclk;
  logic                lrclk;
  logic                s_data;
  logic                sample_req;

  modport master (
    output l_data_en, r_data_en, l_data, r_data,
    input  bclk, lrclk, s_data, sample_req
  );

  modport slave (
    input  l_data_en, r_data_en, l_data, r_data,
    output bclk, lrclk, s_data, sample_req
  );
endinterface

// File: rtl/i2s_dac_transmitter.sv
// Buffered I2S master transmitter: stereo-pair FIFO, bclk/lrclk/s_data from clk division.
// Optional macro I2S_TX_TEST_PATTERN_EN: audio_test forces a fixed L/R pattern into every frame.
module i2s_dac_transmitter #(
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         clear_status,
  input  logic                         audio_test,
  i2s_dac_transmitter_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  output logic                         underrun
);
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } pair_t;

  typedef enum logic [1:0] {IDLE, WAIT_FILL, STREAM} state_t;

  localparam pair_t ZERO_PAIR = '0;

  state_t              state_q, state_d;
  pair_t               mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       count_q;
  logic [SAMPLE_W-1:0] l_hold_q;
  pair_t               cur_q;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                s_data_q, s_data_d;
  logic                sample_req_q;
  logic                overflow_q, underrun_q;

  logic  pop_c, push_c, full_c, empty_c;
  logic  ovf_set_c, unf_set_c, frame_start_c;
  pair_t push_pair_c, head_c, frame_pair_c;

  // Slot layout: bit 0 is the I2S delay bit, bits 1..24 carry MSB..LSB, rest zero.
  function automatic logic slot_bit(input logic [5:0] b, input pair_t p);
    logic [4:0]          slot;
    logic [4:0]          idx;
    logic [SAMPLE_W-1:0] smp;
    slot = b[4:0];
    smp  = b[5] ? p.r : p.l;
    idx  = 5'd24 - slot;
    slot_bit = (slot != 5'd0 && slot <= 5'd24) ? smp[idx] : 1'b0;
  endfunction

  assign full_c      = (count_q == LW'(FIFO_DEPTH));
  assign empty_c     = (count_q == '0);
  assign head_c      = mem[rd_ptr_q];
  assign push_pair_c = '{l: (bus.l_data_en ? bus.l_data : l_hold_q), r: bus.r_data};

  // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
  always_comb begin
    push_c    = run && bus.r_data_en && (!full_c || pop_c);
    ovf_set_c = run && bus.r_data_en && full_c && !pop_c;
  end

`ifdef I2S_TX_TEST_PATTERN_EN
  localparam pair_t TEST_PAIR = '{l: 24'hA50F3C, r: 24'h5AF0C3};
  always_comb frame_pair_c = audio_test ? TEST_PAIR : (pop_c ? head_c : ZERO_PAIR);
`else
  logic unused_audio_test;
  assign unused_audio_test = audio_test;
  always_comb frame_pair_c = pop_c ? head_c : ZERO_PAIR;
`endif

  // Next state, bit/divider counters and serial outputs.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    div_cnt_d     = div_cnt_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    s_data_d      = s_data_q;
    pop_c         = 1'b0;
    unf_set_c     = 1'b0;
    frame_start_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        div_cnt_d = '0;
        bclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        s_data_d  = 1'b0;
        if (run) state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        bit_cnt_d = '0;
        div_cnt_d = '0;
        bclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        s_data_d  = 1'b0;
        if (!run) begin
          state_d = IDLE;
        end else if (!empty_c) begin
          state_d       = STREAM;
          pop_c         = 1'b1;
          frame_start_c = 1'b1;
        end
      end
      STREAM: begin
        if (!run) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          bclk_d    = 1'b0;
          lrclk_d   = 1'b0;
          s_data_d  = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = !bclk_q;
            // Falling bclk: advance the bit and present the next data bit.
            if (bclk_q) begin
              bit_cnt_d = bit_cnt_q + 6'd1;
              lrclk_d   = bit_cnt_d[5];
              s_data_d  = slot_bit(bit_cnt_d, cur_q);
              if (bit_cnt_q == 6'd63) begin
                frame_start_c = 1'b1;
                if (!empty_c) pop_c = 1'b1;
                else          unf_set_c = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, FIFO bookkeeping and sticky status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      s_data_q     <= 1'b0;
      sample_req_q <= 1'b0;
      cur_q        <= ZERO_PAIR;
      l_hold_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      s_data_q     <= s_data_d;
      sample_req_q <= pop_c;
      if (frame_start_c) cur_q <= frame_pair_c;
      if (bus.l_data_en) l_hold_q <= bus.l_data;
      if (!run) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + LW'(push_c) - LW'(pop_c);
      end
      overflow_q <= ovf_set_c | (overflow_q & ~clear_status);
      underrun_q <= unf_set_c | (underrun_q & ~clear_status);
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= push_pair_c;
  end

  assign bus.bclk       = bclk_q;
  assign bus.lrclk      = lrclk_q;
  assign bus.s_data     = s_data_q;
  assign bus.sample_req = sample_req_q;
  assign fifo_level     = count_q;
  assign overflow       = overflow_q;
  assign underrun       = underrun_q;
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Directed bench for i2s_dac_transmitter (BCLK_DIV=2, FIFO_DEPTH=4): frame vectors plus corner sequences.
module tb_i2s_dac_transmitter;
  logic clk = 1'b0;
  logic reset, run, clear_status, audio_test;
  logic [2:0] fifo_level;
  logic overflow, underrun;

  i2s_dac_transmitter_if bus ();

  i2s_dac_transmitter #(.BCLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .run(run), .clear_status(clear_status),
    .audio_test(audio_test), .bus(bus), .fifo_level(fifo_level),
    .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    bit          same;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;

  // Bits and word-select captured at each rising bclk, and sample_req pulses.
  bit   rx_q[$];
  bit   lr_q[$];
  int   req_count = 0;
  logic bclk_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.bclk === 1'b1 && bclk_prev === 1'b0) begin
      rx_q.push_back(bus.s_data);
      lr_q.push_back(bus.lrclk);
    end
    bclk_prev = bus.bclk;
    if (bus.sample_req === 1'b1) req_count++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'h00, 1'b0, r, 7'h00};
  endfunction

  function automatic logic [63:0] get_bits(input int start, input bit use_lr);
    logic [63:0] f = '0;
    for (int i = 0; i < 64; i++) begin
      if (start + i < rx_q.size()) f = {f[62:0], (use_lr ? lr_q[start + i] : rx_q[start + i])};
      else                         f = {f[62:0], 1'b0};
    end
    return f;
  endfunction

  task automatic wait_bits(input int n, input string name);
    int cyc = 0;
    while (rx_q.size() < n && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (rx_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s: timeout with %0d bits, need %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r, input bit same);
    if (!same) begin
      bus.l_data = l; bus.l_data_en = 1'b1;
      tick();
      bus.l_data_en = 1'b0; bus.l_data = ~l;
      bus.r_data = r; bus.r_data_en = 1'b1;
      tick();
      bus.r_data_en = 1'b0;
    end else begin
      bus.l_data = ~l; bus.l_data_en = 1'b1;
      tick();
      bus.l_data = l; bus.r_data = r; bus.r_data_en = 1'b1;
      tick();
      bus.l_data_en = 1'b0; bus.r_data_en = 1'b0;
    end
  endtask

  task automatic restart();
    run = 1'b0; clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    tick();
    run = 1'b1;
    tick();
  endtask

  initial begin
    int base, rbase, n;
    logic [23:0] ol [6];
    logic [23:0] orr [6];

    vecs[0] = '{l: 24'h123456, r: 24'hABCDEF, same: 1'b0, exp: {1'b0, 24'h123456, 7'h00, 1'b0, 24'hABCDEF, 7'h00}};
    vecs[1] = '{l: 24'h000001, r: 24'h7FFFFF, same: 1'b1, exp: {1'b0, 24'h000001, 7'h00, 1'b0, 24'h7FFFFF, 7'h00}};
    vecs[2] = '{l: 24'h800000, r: 24'h000001, same: 1'b0, exp: {1'b0, 24'h800000, 7'h00, 1'b0, 24'h000001, 7'h00}};
    vecs[3] = '{l: 24'hFFFFFF, r: 24'h800000, same: 1'b1, exp: {1'b0, 24'hFFFFFF, 7'h00, 1'b0, 24'h800000, 7'h00}};

    reset = 1'b1; run = 1'b0; clear_status = 1'b0; audio_test = 1'b0;
    bus.l_data_en = 1'b0; bus.r_data_en = 1'b0; bus.l_data = '0; bus.r_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_bclk", 64'(bus.bclk), 64'd0);
    check("rst_lrclk", 64'(bus.lrclk), 64'd0);
    check("rst_sdata", 64'(bus.s_data), 64'd0);
    check("rst_req", 64'(bus.sample_req), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_unf", 64'(underrun), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);

    // WAIT_FILL with an empty FIFO keeps the bit clock stopped.
    tick();
    run = 1'b1;
    base = rx_q.size();
    repeat (12) tick();
    check("waitfill_no_bclk", 64'(rx_q.size() - base), 64'd0);
    check("waitfill_bclk_low", 64'(bus.bclk), 64'd0);

    for (int v = 0; v < 4; v++) begin
      restart();
      base = rx_q.size();
      rbase = req_count;
      push_pair(vecs[v].l, vecs[v].r, vecs[v].same);
      wait_bits(base + 64, $sformatf("vec%0d_wait", v));
      check($sformatf("vec%0d_data", v), get_bits(base, 1'b0), vecs[v].exp);
      check($sformatf("vec%0d_lrclk", v), get_bits(base, 1'b1), LR_EXP);
      check($sformatf("vec%0d_req", v), 64'(req_count - rbase), 64'd1);
    end

    // Latency from STREAM entry, then underrun on the second frame.
    restart();
    base = rx_q.size();
    rbase = req_count;
    push_pair(24'h8ABCDE, 24'h13579B, 1'b0);
    n = 0;
    while (bus.sample_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("lat_req_seen", 64'(bus.sample_req), 64'd1);
    n = 0;
    while (bus.bclk !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("lat_bclk_rise", 64'(n), 64'd2);
    while (bus.bclk !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("lat_msb", {32'(n), 31'd0, bus.s_data}, {32'd4, 31'd0, 1'b1});
    wait_bits(base + 192, "unf_wait");
    check("unf_frame0", get_bits(base, 1'b0), frame_of(24'h8ABCDE, 24'h13579B));
    check("unf_frame1", get_bits(base + 64, 1'b0), 64'd0);
    check("unf_frame2", get_bits(base + 128, 1'b0), 64'd0);
    check("unf_flag", 64'(underrun), 64'd1);
    check("unf_req", 64'(req_count - rbase), 64'd1);

    // Overflow: one pair goes out immediately, four queue, the sixth is dropped.
    restart();
    base = rx_q.size();
    ol[0] = 24'h111111; orr[0] = 24'h222222;
    ol[1] = 24'h333333; orr[1] = 24'h444444;
    ol[2] = 24'h555555; orr[2] = 24'h666666;
    ol[3] = 24'h777777; orr[3] = 24'h888888;
    ol[4] = 24'h999999; orr[4] = 24'hAAAAAA;
    ol[5] = 24'hDEADBE; orr[5] = 24'hEFCAFE;
    for (int i = 0; i < 6; i++) begin
      bus.l_data = ol[i]; bus.r_data = orr[i];
      bus.l_data_en = 1'b1; bus.r_data_en = 1'b1;
      tick();
    end
    bus.l_data_en = 1'b0; bus.r_data_en = 1'b0;
    @(negedge clk);
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);
    wait_bits(base + 6 * 64, "ovf_wait");
    for (int i = 0; i < 5; i++)
      check($sformatf("ovf_frame%0d", i), get_bits(base + 64 * i, 1'b0), frame_of(ol[i], orr[i]));
    check("ovf_dropped", get_bits(base + 320, 1'b0), 64'd0);
    check("ovf_unf", 64'(underrun), 64'd1);

    // Run drop in the right slot, then a fresh frame from bit 0.
    restart();
    base = rx_q.size();
    push_pair(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    push_pair(24'h246802, 24'h135791, 1'b0);
    wait_bits(base + 41, "drop_wait");
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_bclk", 64'(bus.bclk), 64'd0);
    check("drop_lrclk", 64'(bus.lrclk), 64'd0);
    check("drop_sdata", 64'(bus.s_data), 64'd0);
    check("drop_level", 64'(fifo_level), 64'd0);
    tick();
    rbase = rx_q.size();
    run = 1'b1;
    tick();
    push_pair(24'hC0FFEE, 24'h654321, 1'b0);
    wait_bits(rbase + 64, "restart_wait");
    check("restart_data", get_bits(rbase, 1'b0), frame_of(24'hC0FFEE, 24'h654321));
    check("restart_lrclk", get_bits(rbase, 1'b1), LR_EXP);

    // Fixed test pattern while audio_test is high.
    restart();
    base = rx_q.size();
    audio_test = 1'b1;
    push_pair(24'h0A0B0C, 24'h0D0E0F, 1'b0);
    wait_bits(base + 128, "pat_wait");
`ifdef I2S_TX_TEST_PATTERN_EN
    check("pat_frame0", get_bits(base, 1'b0), frame_of(24'hA50F3C, 24'h5AF0C3));
    check("pat_frame1", get_bits(base + 64, 1'b0), frame_of(24'hA50F3C, 24'h5AF0C3));
`else
    check("pat_frame0", get_bits(base, 1'b0), frame_of(24'h0A0B0C, 24'h0D0E0F));
    check("pat_frame1", get_bits(base + 64, 1'b0), 64'd0);
`endif
    check("pat_unf", 64'(underrun), 64'd1);
    audio_test = 1'b0;
    run = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
